// File: rtl/game_pkg.sv
// Shared types and constants for the round judge.
// State encoding, counter widths and default timings.
package game_pkg;

  localparam int TIME_W = 8;
  localparam int LIFE_W = 3;

  localparam int DEF_ROUND_TICKS = 200;
  localparam int DEF_HOLD_TICKS  = 60;
  localparam int DEF_LIVES       = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_WON,
    S_LOST,
    S_OVER
  } judge_state_t;

endpackage

// File: rtl/tick_down_counter.sv
// Loadable down-counter stepped by a tick enable.
// Saturates at zero so the value never wraps.
module tick_down_counter
  import game_pkg::*;
#(
  parameter int W = TIME_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] init,
  input  logic         tick,
  output logic [W-1:0] value,
  output logic         is_one
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= init;
    end else if (tick && value != '0) begin
      value <= value - W'(1);
    end
  end

  assign is_one = (value == W'(1));

endmodule

// File: rtl/round_judge.sv
// Round referee: decides win/lose per timed round,
// tracks lives and holds the result between rounds.
module round_judge
  import game_pkg::*;
#(
  parameter int ROUND_TICKS = DEF_ROUND_TICKS,
  parameter int HOLD_TICKS  = DEF_HOLD_TICKS,
  parameter int LIVES       = DEF_LIVES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              tick,
  input  logic              goal_hit,
  input  logic              player_hit,
  output logic              win,
  output logic              lose,
  output logic              round_active,
  output logic              game_over,
  output logic [TIME_W-1:0] time_left,
  output logic [LIFE_W-1:0] lives_left
);

  localparam logic [TIME_W-1:0] ROUND_INIT = TIME_W'(ROUND_TICKS);
  localparam logic [TIME_W-1:0] HOLD_INIT  = TIME_W'(HOLD_TICKS);
  localparam logic [LIFE_W-1:0] LIFE_INIT  = LIFE_W'(LIVES);

  judge_state_t      state;
  logic [TIME_W-1:0] hold_left;
  logic              time_one;
  logic              hold_one;
  logic              in_play;
  logic              in_hold;
  logic              lose_evt;
  logic              time_load;
  logic              time_dec;
  logic              hold_load;
  logic              hold_dec;

  assign in_play  = (state == S_PLAY);
  assign in_hold  = (state == S_WON) || (state == S_LOST);
  assign lose_evt = player_hit || (tick && time_one);

  assign time_load = (state == S_IDLE)
                  || ((state == S_OVER) && start)
                  || (in_hold && tick && hold_one);
  // The timer freezes on the cycle that ends the round.
  assign time_dec  = in_play && tick && !goal_hit
                  && !player_hit && !time_one;
  assign hold_load = in_play && (goal_hit || lose_evt);
  assign hold_dec  = in_hold && tick;

  tick_down_counter #(.W(TIME_W)) u_round (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (time_load),
    .init   (ROUND_INIT),
    .tick   (time_dec),
    .value  (time_left),
    .is_one (time_one)
  );

  tick_down_counter #(.W(TIME_W)) u_hold (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (hold_load),
    .init   (HOLD_INIT),
    .tick   (hold_dec),
    .value  (hold_left),
    .is_one (hold_one)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      lives_left <= '0;
      win        <= 1'b0;
      lose       <= 1'b0;
    end else begin
      win  <= 1'b0;
      lose <= 1'b0;
      unique case (state)
        S_IDLE: begin
          lives_left <= LIFE_INIT;
          if (start) state <= S_PLAY;
        end
        S_PLAY: begin
          if (goal_hit) begin
            win   <= 1'b1;
            state <= S_WON;
          end else if (lose_evt) begin
            lose <= 1'b1;
            if (lives_left != '0)
              lives_left <= lives_left - LIFE_W'(1);
            state <= (lives_left <= LIFE_W'(1)) ? S_OVER : S_LOST;
          end
        end
        S_WON, S_LOST: begin
          if (tick && hold_one) state <= S_PLAY;
        end
        S_OVER: begin
          if (start) begin
            lives_left <= LIFE_INIT;
            state      <= S_PLAY;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign round_active = in_play;
  assign game_over    = (state == S_OVER);

endmodule

// File: tb/tb_round_judge.sv
// Bench for round_judge: directed scenarios plus random
// stimulus, all compared every cycle to a reference model.
module tb_round_judge;

  localparam int RT = 200;
  localparam int HT = 60;
  localparam int LV = 3;

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_HOLD = 2;
  localparam int M_OVER = 3;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       tick;
  logic       goal_hit;
  logic       player_hit;
  logic       win;
  logic       lose;
  logic       round_active;
  logic       game_over;
  logic [7:0] time_left;
  logic [2:0] lives_left;

  int checks;
  int failures;

  int m_mode;
  int m_time;
  int m_lives;
  int m_hold;
  int m_win;
  int m_lose;

  round_judge #(
    .ROUND_TICKS (RT),
    .HOLD_TICKS  (HT),
    .LIVES       (LV)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .tick         (tick),
    .goal_hit     (goal_hit),
    .player_hit   (player_hit),
    .win          (win),
    .lose         (lose),
    .round_active (round_active),
    .game_over    (game_over),
    .time_left    (time_left),
    .lives_left   (lives_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got,
                       input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference: a round is a budget of RT ticks, a game is
  // a budget of LV losses, a result is shown for HT ticks.
  task automatic model_step();
    m_win  = 0;
    m_lose = 0;
    if (!rst_n) begin
      m_mode  = M_IDLE;
      m_time  = 0;
      m_lives = 0;
      m_hold  = 0;
      return;
    end
    case (m_mode)
      M_IDLE: begin
        m_time  = RT;
        m_lives = LV;
        if (start) m_mode = M_PLAY;
      end
      M_PLAY: begin
        if (goal_hit) begin
          m_win  = 1;
          m_mode = M_HOLD;
          m_hold = HT;
        end else if (player_hit || (tick && m_time == 1)) begin
          m_lose  = 1;
          m_lives = m_lives - 1;
          m_hold  = HT;
          m_mode  = (m_lives == 0) ? M_OVER : M_HOLD;
        end else if (tick) begin
          m_time = m_time - 1;
        end
      end
      M_HOLD: begin
        if (tick) begin
          m_hold = m_hold - 1;
          if (m_hold == 0) begin
            m_mode = M_PLAY;
            m_time = RT;
          end
        end
      end
      default: begin
        if (start) begin
          m_mode  = M_PLAY;
          m_lives = LV;
          m_time  = RT;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check("win", int'(win), m_win);
    check("lose", int'(lose), m_lose);
    check("round_active", int'(round_active),
          int'(m_mode == M_PLAY));
    check("game_over", int'(game_over),
          int'(m_mode == M_OVER));
    check("time_left", int'(time_left), m_time);
    check("lives_left", int'(lives_left), m_lives);
  endtask

  task automatic step(input logic s, input logic t,
                      input logic g, input logic p);
    start      = s;
    tick       = t;
    goal_hit   = g;
    player_hit = p;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    m_mode     = M_IDLE;
    m_time     = 0;
    m_lives    = 0;
    m_hold     = 0;
    m_win      = 0;
    m_lose     = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    tick       = 1'b0;
    goal_hit   = 1'b0;
    player_hit = 1'b0;

    step(0, 0, 0, 0);
    check("rst_time", int'(time_left), 0);
    check("rst_lives", int'(lives_left), 0);
    check("rst_active", int'(round_active), 0);

    rst_n = 1'b1;
    step(1, 0, 0, 0);
    check("start_active", int'(round_active), 1);
    check("start_time", int'(time_left), RT);
    check("start_lives", int'(lives_left), LV);

    ticks(5);
    check("time_after5", int'(time_left), 195);
    step(0, 0, 1, 0);
    check("goal_win", int'(win), 1);
    step(0, 1, 0, 0);
    check("win_one_cycle", int'(win), 0);
    check("time_frozen", int'(time_left), 195);
    ticks(58);
    check("hold_59", int'(round_active), 0);
    ticks(1);
    check("hold_done", int'(round_active), 1);
    check("time_reload", int'(time_left), RT);

    step(0, 0, 1, 1);
    check("both_win", int'(win), 1);
    check("both_nolose", int'(lose), 0);
    check("both_lives", int'(lives_left), 3);
    ticks(HT);

    ticks(RT - 1);
    check("timeout_pre", int'(lose), 0);
    check("timeout_t1", int'(time_left), 1);
    ticks(1);
    check("timeout_lose", int'(lose), 1);
    check("timeout_lives", int'(lives_left), 2);
    check("timeout_lost", int'(round_active), 0);
    ticks(HT);

    rst_n = 1'b0;
    step(0, 0, 0, 0);
    rst_n = 1'b1;
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      check("hit_lose", int'(lose), 1);
      if (i < 2) ticks(HT);
    end
    check("over_flag", int'(game_over), 1);
    check("over_lives", int'(lives_left), 0);
    step(0, 0, 0, 1);
    check("over_nohit", int'(lose), 0);
    step(1, 0, 0, 0);
    check("restart_lives", int'(lives_left), 3);
    check("restart_active", int'(round_active), 1);

    step(1, 1, 0, 0);
    check("start_in_play", int'(round_active), 1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    check("goal_in_won", int'(win), 0);
    ticks(HT);

    rst_n = 1'b0;
    step(0, 0, 1, 0);
    check("rst_goal_win", int'(win), 0);
    check("rst_goal_active", int'(round_active), 0);
    check("rst_goal_time", int'(time_left), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 20000; i++) begin
      rst_n = ($urandom_range(0, 2999) != 0);
      step(logic'($urandom_range(0, 29) == 0),
           logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 249) == 0),
           logic'($urandom_range(0, 249) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
